// File: rtl/bingo_pkg.sv
// Shared types and width helpers for the BinGo judge.
// Latency: n/a; backpressure: n/a (declarations only).
package bingo_pkg;

    typedef enum logic [2:0] {
        FILL,
        ARMED,
        IDLE,
        SCAN,
        CHECK,
        DONE
    } state_t;

    localparam int DEF_PLAYERS   = 2;
    localparam int DEF_CARD_SIZE = 8;

    function automatic int num_entries(input int players, input int card_size);
        return players * card_size;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int score_w(input int card_size);
        return $clog2(card_size + 1);
    endfunction

    function automatic int winner_w(input int players);
        return idx_w(players);
    endfunction

    localparam int NUM_ENTRIES = num_entries(DEF_PLAYERS, DEF_CARD_SIZE);

endpackage

// File: rtl/bingo_card_mem.sv
// Card number storage: one write port for loading, one combinational read port for scanning.
// Latency: write lands on the next edge, read is same-cycle; backpressure: none (caller gates we).
module bingo_card_mem
    import bingo_pkg::*;
#(
    parameter int DEPTH = NUM_ENTRIES,
    parameter int NUM_W = 8
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [idx_w(DEPTH)-1:0]   waddr,
    input  logic [NUM_W-1:0]          wdata,
    input  logic [idx_w(DEPTH)-1:0]   raddr,
    output logic [NUM_W-1:0]          rdata
);

    logic [NUM_W-1:0] mem [DEPTH];

    // No reset: contents are meaningless until the card is loaded.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bingo_judge_n.sv
// BinGo judge: loads PLAYERS cards, scans each draw against every entry, scores and declares winner/tie.
// Latency: next -> hit/busy low in N+2 cycles; backpressure: load_ready only in FILL, next dropped unless IDLE.
module bingo_judge_n
    import bingo_pkg::*;
#(
    parameter int PLAYERS   = DEF_PLAYERS,
    parameter int CARD_SIZE = DEF_CARD_SIZE,
    parameter int NUM_W     = 8
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   load_valid,
    input  logic [NUM_W-1:0]                       load_data,
    output logic                                   load_ready,
    input  logic                                   start,
    input  logic                                   next,
    input  logic [NUM_W-1:0]                       draw_number,
    output logic                                   busy,
    output logic                                   hit,
    output logic [PLAYERS*CARD_SIZE-1:0]           game_state,
    output logic [PLAYERS*score_w(CARD_SIZE)-1:0]  scores,
    output logic                                   endgame,
    output logic [winner_w(PLAYERS)-1:0]           winner,
    output logic                                   tie
);

    localparam int N  = num_entries(PLAYERS, CARD_SIZE);
    localparam int SW = score_w(CARD_SIZE);
    localparam int WW = winner_w(PLAYERS);
    localparam int AW = idx_w(N);
    localparam int PW = $clog2(N + 1);
    localparam int EW = idx_w(CARD_SIZE);

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [AW-1:0]    scan_idx;
    logic [EW-1:0]    scan_ent;
    logic [WW-1:0]    scan_pl;
    logic [NUM_W-1:0] draw_q;
    logic             turn_hit;
    logic [N-1:0]     match_q;
    logic [SW-1:0]    score_q [PLAYERS];
    logic [NUM_W-1:0] rd_data;
    logic             mem_we;
    logic             any_done;
    logic             multi_done;
    logic [WW-1:0]    first_done;

    assign load_ready = (state == FILL);
    assign mem_we     = load_valid && load_ready;
    assign game_state = match_q;

    bingo_card_mem #(
        .DEPTH (N),
        .NUM_W (NUM_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (ptr[AW-1:0]),
        .wdata (load_data),
        .raddr (scan_idx),
        .rdata (rd_data)
    );

    always_comb begin
        scores = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            scores[p*SW +: SW] = score_q[p];
        end
    end

    // Lowest-index completed player wins; a second completion marks a tie.
    always_comb begin
        any_done   = 1'b0;
        multi_done = 1'b0;
        first_done = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            if (score_q[p] == SW'(CARD_SIZE)) begin
                if (any_done) begin
                    multi_done = 1'b1;
                end else begin
                    first_done = WW'(p);
                end
                any_done = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= FILL;
            ptr      <= '0;
            scan_idx <= '0;
            scan_ent <= '0;
            scan_pl  <= '0;
            draw_q   <= '0;
            turn_hit <= 1'b0;
            match_q  <= '0;
            busy     <= 1'b0;
            hit      <= 1'b0;
            endgame  <= 1'b0;
            winner   <= '0;
            tie      <= 1'b0;
            for (int p = 0; p < PLAYERS; p++) begin
                score_q[p] <= '0;
            end
        end else begin
            hit <= 1'b0;
            case (state)
                FILL: begin
                    if (load_valid) begin
                        ptr <= ptr + PW'(1);
                        if (ptr == PW'(N - 1)) begin
                            state <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (start) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (next) begin
                        draw_q   <= draw_number;
                        scan_idx <= '0;
                        scan_ent <= '0;
                        scan_pl  <= '0;
                        turn_hit <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    // Match bits, not value zeroing, mark struck entries so 00 stays a legal number.
                    if (rd_data == draw_q && !match_q[scan_idx]) begin
                        match_q[scan_idx] <= 1'b1;
                        score_q[scan_pl]  <= score_q[scan_pl] + SW'(1);
                        turn_hit          <= 1'b1;
                    end
                    if (scan_idx == AW'(N - 1)) begin
                        state <= CHECK;
                    end else begin
                        scan_idx <= scan_idx + AW'(1);
                        if (scan_ent == EW'(CARD_SIZE - 1)) begin
                            scan_ent <= '0;
                            scan_pl  <= scan_pl + WW'(1);
                        end else begin
                            scan_ent <= scan_ent + EW'(1);
                        end
                    end
                end
                CHECK: begin
                    busy <= 1'b0;
                    hit  <= turn_hit;
                    if (any_done) begin
                        endgame <= 1'b1;
                        winner  <= first_done;
                        tie     <= multi_done;
                        state   <= DONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_bingo_judge_n.sv
// Randomised self-checking bench for bingo_judge_n against a card/strike-list reference model.
module tb_bingo_judge_n;
    import bingo_pkg::*;

    localparam int P  = DEF_PLAYERS;
    localparam int C  = DEF_CARD_SIZE;
    localparam int N  = NUM_ENTRIES;
    localparam int SW = score_w(C);
    localparam int WW = winner_w(P);
    localparam int VW = N + P*SW + 1 + WW + 1;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           load_valid = 1'b0;
    logic [7:0]     load_data = '0;
    logic           start = 1'b0;
    logic           next = 1'b0;
    logic [7:0]     draw_number = '0;
    logic           load_ready, busy, hit, endgame, tie;
    logic [N-1:0]   game_state;
    logic [P*SW-1:0] scores;
    logic [WW-1:0]  winner;
    logic [VW-1:0]  dut_vec;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] card [N];
    bit         matched [N];
    bit         m_end, m_tie;
    int         m_win;

    always #5 clk = ~clk;

    bingo_judge_n #(.PLAYERS(P), .CARD_SIZE(C), .NUM_W(8)) dut (
        .clk(clk), .rstn(rstn),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .start(start), .next(next), .draw_number(draw_number),
        .busy(busy), .hit(hit), .game_state(game_state), .scores(scores),
        .endgame(endgame), .winner(winner), .tie(tie)
    );

    assign dut_vec = {game_state, scores, endgame, winner, tie};

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < N; i++) matched[i] = 1'b0;
        m_end = 1'b0; m_tie = 1'b0; m_win = 0;
    endfunction

    function automatic bit model_draw(input logic [7:0] d);
        bit h = 1'b0;
        int nd = 0;
        if (m_end) return 1'b0;
        for (int i = 0; i < N; i++) begin
            if (card[i] == d && !matched[i]) begin
                matched[i] = 1'b1;
                h = 1'b1;
            end
        end
        for (int p = 0; p < P; p++) begin
            int cnt = 0;
            for (int e = 0; e < C; e++) cnt += int'(matched[p*C+e]);
            if (cnt == C) begin
                if (nd == 0) m_win = p;
                nd++;
            end
        end
        if (nd > 0) begin
            m_end = 1'b1;
            m_tie = (nd > 1);
        end
        return h;
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [N-1:0]    gs = '0;
        logic [P*SW-1:0] sc = '0;
        for (int i = 0; i < N; i++) begin
            if (matched[i]) begin
                gs[i] = 1'b1;
                sc[(i/C)*SW +: SW] = sc[(i/C)*SW +: SW] + SW'(1);
            end
        end
        return {gs, sc, m_end, WW'(m_win), m_tie};
    endfunction

    // ---------------- drivers ----------------
    task automatic apply_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        model_reset();
    endtask

    task automatic fill_drive(output int writes, output int first_low);
        writes = 0; first_low = 0;
        for (int c = 1; c <= 20; c++) begin
            load_valid = 1'b1;
            load_data  = (writes < N) ? card[writes] : 8'hEE;
            if (load_ready) writes++;
            else if (first_low == 0) first_low = c;
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_turn(input logic [7:0] d, input int inj_k, input logic [7:0] inj_d,
                            output bit busy_ok, output logic hit_obs);
        busy_ok = 1'b1; hit_obs = 1'b0;
        draw_number = d; next = 1'b1;
        for (int k = 1; k <= N + 2; k++) begin
            @(posedge clk); #1;
            next = 1'b0;
            draw_number = 8'($urandom);
            if (k == inj_k) begin
                next = 1'b1;
                draw_number = inj_d;
            end
            if (k <= N + 1) begin
                if (busy !== 1'b1 || hit !== 1'b0) busy_ok = 1'b0;
            end else begin
                if (busy !== 1'b0) busy_ok = 1'b0;
                hit_obs = hit;
            end
        end
        next = 1'b0;
    endtask

    task automatic plan_card();
        for (int i = 0; i < N; i++) card[i] = (i < C) ? 8'(8'h01 + i) : 8'(8'h11 + i - C);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_vec++;
        if (load_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_load_ready: got %b expected 1", load_ready);
        end
        n_vec++;
        if ({busy, hit, dut_vec} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", {busy, hit, dut_vec});
        end
    endtask

    task automatic test_fill();
        int w, fl;
        plan_card();
        fill_drive(w, fl);
        n_vec++;
        if (w !== N) begin
            n_err++; $display("FAIL fill_writes: got %0d expected %0d", w, N);
        end
        n_vec++;
        if (fl !== N + 1) begin
            n_err++; $display("FAIL fill_ready_drop: low from cycle %0d expected %0d", fl, N + 1);
        end
    endtask

    task automatic test_armed_gating();
        bit saw_busy = 1'b0;
        draw_number = 8'h01; next = 1'b1;
        for (int k = 0; k < N + 3; k++) begin
            @(posedge clk); #1;
            next = 1'b0;
            if (busy !== 1'b0 || hit !== 1'b0) saw_busy = 1'b1;
        end
        n_vec++;
        if (saw_busy || game_state !== '0) begin
            n_err++; $display("FAIL armed_next_ignored: busy_seen=%b gs=%h expected 0/0", saw_busy, game_state);
        end
        pulse_start();
    endtask

    task automatic test_basic();
        bit bok; logic h; bit eh;
        logic [7:0] draws [3];
        draws[0] = 8'h05; draws[1] = 8'h05; draws[2] = 8'h99;
        for (int t = 0; t < 3; t++) begin
            eh = model_draw(draws[t]);
            run_turn(draws[t], 0, 8'h00, bok, h);
            n_vec++;
            if ({bok, h, dut_vec} !== {1'b1, eh, model_vec()}) begin
                n_err++; $display("FAIL basic_turn%0d: got %h expected %h", t, {bok, h, dut_vec}, {1'b1, eh, model_vec()});
            end
            if (t == 0) begin
                n_vec++;
                if (game_state !== 16'h0010 || scores !== 8'h01) begin
                    n_err++; $display("FAIL draw05_state: got gs=%h sc=%h expected 0010/01", game_state, scores);
                end
                @(posedge clk); #1;
                n_vec++;
                if (hit !== 1'b0) begin
                    n_err++; $display("FAIL hit_pulse_width: got %b expected 0", hit);
                end
            end
        end
    endtask

    task automatic test_next_while_busy();
        bit bok; logic h; bit eh; bit relaunch = 1'b0;
        eh = model_draw(8'h11);
        run_turn(8'h11, 3, 8'h12, bok, h);
        n_vec++;
        if ({bok, h, dut_vec} !== {1'b1, eh, model_vec()}) begin
            n_err++; $display("FAIL busy_drop_turn: got %h expected %h", {bok, h, dut_vec}, {1'b1, eh, model_vec()});
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0) relaunch = 1'b1;
        end
        n_vec++;
        if (relaunch || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL busy_drop_queued: relaunch=%b vec=%h expected 0/%h", relaunch, dut_vec, model_vec());
        end
    endtask

    task automatic test_win();
        bit bok; logic h; bit eh;
        for (int v = 1; v <= 8; v++) begin
            eh = model_draw(8'(v));
            run_turn(8'(v), 0, 8'h00, bok, h);
            n_vec++;
            if ({bok, h, dut_vec} !== {1'b1, eh, model_vec()}) begin
                n_err++; $display("FAIL win_turn%0d: got %h expected %h", v, {bok, h, dut_vec}, {1'b1, eh, model_vec()});
            end
        end
        n_vec++;
        if ({endgame, winner, tie} !== {1'b1, {WW{1'b0}}, 1'b0}) begin
            n_err++; $display("FAIL win_result: got %b expected endgame=1 winner=0 tie=0", {endgame, winner, tie});
        end
    endtask

    task automatic test_frozen();
        bit moved = 1'b0;
        next = 1'b1; start = 1'b1; load_valid = 1'b1; draw_number = 8'h11; load_data = 8'h11;
        repeat (3) @(posedge clk);
        #1 next = 1'b0; start = 1'b0; load_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || hit !== 1'b0 || load_ready !== 1'b0) moved = 1'b1;
        end
        n_vec++;
        if (moved || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL done_frozen: moved=%b vec=%h expected 0/%h", moved, dut_vec, model_vec());
        end
    endtask

    task automatic test_reset_mid_scan();
        int w, fl;
        apply_reset();
        plan_card();
        fill_drive(w, fl);
        pulse_start();
        draw_number = 8'h01; next = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            next = 1'b0;
        end
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL midscan_busy: got %b expected 1", busy);
        end
        rstn = 1'b0;
        #1;
        n_vec++;
        if ({busy, hit, dut_vec} !== '0) begin
            n_err++; $display("FAIL midscan_reset_outputs: got %h expected 0", {busy, hit, dut_vec});
        end
        @(posedge clk); #1;
        n_vec++;
        if (load_ready !== 1'b1) begin
            n_err++; $display("FAIL midscan_load_ready: got %b expected 1", load_ready);
        end
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_tie();
        int w, fl; bit bok; logic h; bit eh;
        logic [7:0] pre [2*(C-1)];
        logic [7:0] tmp;
        apply_reset();
        for (int e = 0; e < C - 1; e++) begin
            card[e]     = 8'(8'h21 + e);
            card[C + e] = 8'(8'h31 + e);
            pre[e]         = card[e];
            pre[C - 1 + e] = card[C + e];
        end
        card[C - 1] = 8'h07; card[N - 1] = 8'h07;
        for (int i = 2*(C-1) - 1; i > 0; i--) begin
            int j = int'($urandom_range(0, i));
            tmp = pre[i]; pre[i] = pre[j]; pre[j] = tmp;
        end
        fill_drive(w, fl);
        pulse_start();
        for (int t = 0; t <= 2*(C-1); t++) begin
            logic [7:0] d = (t < 2*(C-1)) ? pre[t] : 8'h07;
            eh = model_draw(d);
            run_turn(d, 0, 8'h00, bok, h);
            n_vec++;
            if ({bok, h, dut_vec} !== {1'b1, eh, model_vec()}) begin
                n_err++; $display("FAIL tie_turn%0d: got %h expected %h", t, {bok, h, dut_vec}, {1'b1, eh, model_vec()});
            end
        end
        n_vec++;
        if ({endgame, winner, tie} !== {1'b1, {WW{1'b0}}, 1'b1} || scores !== 8'h88) begin
            n_err++; $display("FAIL tie_result: got eg/win/tie=%b sc=%h expected 101/88", {endgame, winner, tie}, scores);
        end
    endtask

    task automatic test_random();
        int w, fl; bit bok; logic h; bit eh; logic [7:0] d;
        for (int g = 0; g < 3; g++) begin
            apply_reset();
            for (int i = 0; i < N; i++) card[i] = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
            fill_drive(w, fl);
            pulse_start();
            for (int t = 0; t < 60 && !m_end; t++) begin
                d = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
                eh = model_draw(d);
                run_turn(d, 0, 8'h00, bok, h);
                n_vec++;
                if ({bok, h, dut_vec} !== {1'b1, eh, model_vec()}) begin
                    n_err++; $display("FAIL rand_g%0d_t%0d draw %h: got %h expected %h", g, t, d, {bok, h, dut_vec}, {1'b1, eh, model_vec()});
                end
            end
        end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_fill();
        test_armed_gating();
        test_basic();
        test_next_while_busy();
        test_win();
        test_frozen();
        test_reset_mid_scan();
        test_tie();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bingo_judge_n.md
Name: bingo_judge_n

Overview:
- Parametrised successor to the two-player, eight-number BinGo game engine.
- Stores PLAYERS cards of CARD_SIZE BCD numbers each, accepts drawn numbers one per turn, and scans every card entry for matches.
- Tracks per-player scores and declares a winner or a tie.
- Sits between keyboard_ctrl (card entry, start) and the draw source (lfsr_prng or hack mux), and feeds visualization.

Parameters:
- PLAYERS, 2, number of players (2..8).
- CARD_SIZE, 8, numbers per card (1..16).
- NUM_W, 8, width of a stored/drawn number (two BCD digits).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- load_valid  in  1  card entry valid.
- load_data  in  NUM_W  card entry value.
- load_ready  out  1  high while card memory not full and FSM in FILL.
- start  in  1  single-cycle pulse: begin game.
- next  in  1  single-cycle pulse: judge draw_number.
- draw_number  in  NUM_W  number to judge, sampled on next.
- busy  out  1  scan in progress; next ignored while high.
- hit  out  1  one-cycle pulse at end of a turn with at least one new match.
- game_state  out  PLAYERS*CARD_SIZE  bit p*CARD_SIZE+k set when player p entry k is matched.
- scores  out  PLAYERS*SW  matched count per player, SW=$clog2(CARD_SIZE+1).
- endgame  out  1  game over, sticky until reset.
- winner  out  WW  lowest-index completed player, WW=max(1,$clog2(PLAYERS)).
- tie  out  1  more than one player completed on the same turn.

Behaviour:
- Async reset (rstn low): state FILL, write pointer 0, all match bits 0, scores 0, busy/hit/endgame/tie 0, winner 0. Memory contents are don't-care.
- FILL: load_ready=1. Each load_valid&load_ready cycle writes mem[ptr] and increments ptr. Entries are assigned in order player 0 entries 0..CARD_SIZE-1, then player 1, and so on. At ptr=PLAYERS*CARD_SIZE, load_ready drops the next cycle and the FSM moves to ARMED. load_valid while full is ignored.
- ARMED: waits for start; start then moves to IDLE. start in FILL is ignored.
- IDLE: next moves to SCAN, latches draw_number, and sets busy=1 the next cycle.
- SCAN:
  - One entry per cycle, idx 0..N-1 (N=PLAYERS*CARD_SIZE).
  - If mem[idx]==latched draw and the match bit is clear: set the match bit, increment that player's score, and set the turn-hit flag.
  - Duplicate values are allowed; every matching entry is cleared.
  - Matching a number already matched changes nothing.
- CHECK (1 cycle after last scan):
  - busy=0; hit pulses if the turn-hit flag is set.
  - For every player with score==CARD_SIZE: endgame=1, winner=lowest such index, tie=1 if the count is >1. FSM then goes to DONE, otherwise IDLE.
  - Turn latency from next to hit/busy low is N+2 cycles.
- DONE: all inputs ignored; outputs hold until reset.
- next and start arriving in the same cycle: only the input relevant to the current state acts.
- next while busy: dropped, not queued.
- Reset mid-scan: immediate return to FILL; the card must be reloaded.
- Entry value 8'h00 is a legal card number (match bits, not zeroing, mark cleared entries).

Decomposition:
- Package bingo_pkg:
  - state enum {FILL, ARMED, IDLE, SCAN, CHECK, DONE}.
  - Width helper functions for SW and WW.
  - Constant NUM_ENTRIES.
- One sub-module, bingo_card_mem: N x NUM_W register array with write port (load) and combinational read port (scan index).
- Score counting and winner priority live in the top FSM.

Test Plan:
- Fill with PLAYERS=2, CARD_SIZE=8, values 01..08, 11..18, then start; next with draw 05 -> after 18 cycles hit=1, game_state=16'h0010, scores P0=1 P1=0.
- Draw 05 again -> hit stays 0, game_state unchanged; draw 99 -> hit 0, busy low after 18 cycles.
- Draw 01..08 in turn -> endgame=1 on 8th CHECK, winner=0, tie=0; further next/start leave all outputs frozen.
- Card with 07 in both P0 entry 7 and P1 entry 7, the remaining entries pre-matched -> draw 07 gives endgame=1, winner=0, tie=1, both scores 8.
- Pulse next at busy cycle 3 -> ignored, only one turn judged; assert rstn low mid-SCAN -> outputs return to reset values, load_ready=1 next cycle.
- Fill attempt with load_valid held for 20 cycles -> exactly 16 writes, load_ready low from cycle 17.
